decoder: RTL and testbench
==========================

// Module: decoder
// PURPOSE
//  Decode/operand-read stage feeding the executer. Accepts RV32I words from fetch and
//  decodes them into control_info (def.sv). Reads rs1/rs2 from an internal register file
//  and presents a registered operand bundle downstream through a valid/ready handshake.
//  Holds a scoreboard of in-flight destination registers and stalls on RAW hazards
//  until writeback retires them.
// PARAMETERS
//  XLEN      32   operand/register width
//  NREG      32   architectural registers (x0 hard-wired to 0)
// PORTS
//  CLK        in   1     clock; all state updates on posedge CLK
//  RST        in   1     synchronous reset, active-high
//  IN_VALID   in   1     fetch presents INSTR
//  IN_READY   out  1     decoder accepts INSTR this cycle
//  INSTR      in   32    RV32I instruction word
//  OUT_VALID  out  1     output bundle valid
//  OUT_READY  in   1     executer takes bundle this cycle
//  CTR_INFO   out  ctrl  control_info struct (one-hot op, use_imm, wb_en, illegal)
//  RS1_VAL    out  XLEN  rs1 operand
//  RS2_VAL    out  XLEN  rs2 operand (always the register, even when use_imm)
//  IMM        out  XLEN  sign-extended immediate (I/U types; 0 for R-type)
//  RD_ADDR    out  5     destination register index
//  WB_EN      in   1     writeback strobe
//  WB_ADDR    in   5     writeback register
//  WB_DATA    in   XLEN  writeback value
// BEHAVIOUR
//  - Reset: OUT_VALID=0; CTR_INFO, RS1_VAL, RS2_VAL, IMM, RD_ADDR=0; scoreboard cleared.
//    Register file contents are not reset; x0 reads 0. RST mid-stall drops the held bundle.
//  - Latency: 1 cycle from accept (IN_VALID&&IN_READY) to OUT_VALID.
//  - IN_READY = !hazard && (!OUT_VALID || OUT_READY).
//  - hazard = (used rs1 pending && !(WB_EN && WB_ADDR==rs1)) or the same for rs2. rs2 is
//    checked only for R-type. x0 is never pending.
//  - Bypass: a read of a register being written this cycle returns WB_DATA. x0 stays 0.
//  - Output register loads on accept. Output holds stable while OUT_VALID && !OUT_READY.
//    OUT_VALID clears when OUT_READY is high and no new accept occurs.
//  - Scoreboard: on accept with wb_en && rd!=0, set pending[rd]. On WB_EN, clear
//    pending[WB_ADDR]. If set and clear hit the same index in one cycle, set wins.
//  - Decoded set, one-hot in CTR_INFO:
//    - add, sub, and, or, xor, slt, sltu, sll, srl, sra: R-type and I-type; I-type sets
//      use_imm, and sub has no I form.
//    - lui: IMM = {INSTR[31:12], 12'b0}.
//  - Any other opcode/funct combination: illegal=1, all op bits 0, wb_en=0. It still
//    flows downstream; no scoreboard update.
//  - Shift-immediate: IMM = {27'b0, shamt}. srai is selected by INSTR[30].
// STRUCTURE
//  - def.sv package:
//    - control_info struct, extended with use_imm, wb_en, illegal, lui, logic ops.
//    - opcode localparams OP_R=7'b0110011, OP_I=7'b0010011, OP_LUI=7'b0110111.
//    - funct3 localparams.
//  - Sub-module reg_file: 2 async read ports plus 1 sync write port with write-through
//    bypass, x0 forced 0.
//  - Decode logic and scoreboard stay in decoder.
// TESTING
//  1. Reset, then addi x1,x0,5 (0x00500093) -> next cycle OUT_VALID=1, add=1, use_imm=1,
//     IMM=5, RD_ADDR=1, pending[1]=1.
//  2. add x3,x1,x2 while pending[1]=1, no WB -> IN_READY=0. Then WB_EN x1=5 ->
//     same-cycle accept, RS1_VAL=5 via bypass.
//  3. OUT_READY=0 for 3 cycles with a valid bundle -> outputs stable, IN_READY=0.
//     OUT_READY=1 -> bundle consumed, next accepted.
//  4. sub x5,x6,x7 with x6=10, x7=3 -> sub=1, RS1_VAL=10, RS2_VAL=3, use_imm=0.
//  5. INSTR=0xFFFFFFFF -> illegal=1, wb_en=0, no pending bit set.
//     lui x4,0x12345 -> IMM=0x12345000.
//  6. Accept addi x2 in the same cycle WB_EN clears x2 -> pending[2]=1.
//     Assert RST with OUT_VALID=1 -> next cycle OUT_VALID=0, scoreboard empty.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the RV32I decode / operand-read stage.
//   XLEN, NREG, REG_AW : datapath width, register count, register index width
//   OP_* / F3_* / F7_* : opcode, funct3 and funct7 encodings for the decoded subset
//   control_info_t     : one-hot operation plus use_imm / wb_en / illegal flags
//   decode_t           : control info plus operand usage and immediate
//   decode_instr()     : pure combinational decoder for one instruction word
package decoder_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction format, used only to steer immediate/operand selection.
    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_U   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef struct packed {
        logic op_add;
        logic op_sub;
        logic op_and;
        logic op_or;
        logic op_xor;
        logic op_slt;
        logic op_sltu;
        logic op_sll;
        logic op_srl;
        logic op_sra;
        logic op_lui;
        logic use_imm;
        logic wb_en;
        logic illegal;
    } control_info_t;

    typedef struct packed {
        control_info_t ctrl;
        logic          use_rs1;
        logic          use_rs2;
        logic [31:0]   imm;
    } decode_t;

    function automatic fmt_e instr_fmt(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP_R:    f = FMT_R;
            OP_I:    f = FMT_I;
            OP_LUI:  f = FMT_U;
            default: f = FMT_BAD;
        endcase
        return f;
    endfunction

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic       ill;
        logic [6:0] f7;
        logic [2:0] f3;
        d   = '0;
        ill = 1'b0;
        f7  = instr[31:25];
        f3  = instr[14:12];
        case (instr_fmt(instr[6:0]))
            FMT_R: begin
                d.use_rs1    = 1'b1;
                d.use_rs2    = 1'b1;
                d.ctrl.wb_en = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD_SUB: d.ctrl.op_add  = 1'b1;
                        F3_SLL:     d.ctrl.op_sll  = 1'b1;
                        F3_SLT:     d.ctrl.op_slt  = 1'b1;
                        F3_SLTU:    d.ctrl.op_sltu = 1'b1;
                        F3_XOR:     d.ctrl.op_xor  = 1'b1;
                        F3_SRL_SRA: d.ctrl.op_srl  = 1'b1;
                        F3_OR:      d.ctrl.op_or   = 1'b1;
                        default:    d.ctrl.op_and  = 1'b1;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
                    d.ctrl.op_sub = 1'b1;
                end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
                    d.ctrl.op_sra = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            FMT_I: begin
                d.use_rs1      = 1'b1;
                d.ctrl.use_imm = 1'b1;
                d.ctrl.wb_en   = 1'b1;
                d.imm          = {{20{instr[31]}}, instr[31:20]};
                case (f3)
                    F3_ADD_SUB: d.ctrl.op_add  = 1'b1;
                    F3_SLT:     d.ctrl.op_slt  = 1'b1;
                    F3_SLTU:    d.ctrl.op_sltu = 1'b1;
                    F3_XOR:     d.ctrl.op_xor  = 1'b1;
                    F3_OR:      d.ctrl.op_or   = 1'b1;
                    F3_AND:     d.ctrl.op_and  = 1'b1;
                    F3_SLL: begin
                        d.imm = {27'b0, instr[24:20]};
                        if (f7 == F7_BASE) d.ctrl.op_sll = 1'b1;
                        else               ill = 1'b1;
                    end
                    default: begin
                        // srli/srai share funct3; bit 30 picks arithmetic.
                        d.imm = {27'b0, instr[24:20]};
                        if (f7 == F7_BASE)     d.ctrl.op_srl = 1'b1;
                        else if (f7 == F7_ALT) d.ctrl.op_sra = 1'b1;
                        else                   ill = 1'b1;
                    end
                endcase
            end
            FMT_U: begin
                d.ctrl.op_lui  = 1'b1;
                d.ctrl.use_imm = 1'b1;
                d.ctrl.wb_en   = 1'b1;
                d.imm          = {instr[31:12], 12'b0};
            end
            default: ill = 1'b1;
        endcase
        // Illegal words carry only the flag: no ops, no writeback, no operand use.
        if (ill) begin
            d              = '0;
            d.ctrl.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/decoder_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
//   CLK      : clock
//   RA1/RA2  : read addresses;  RD1/RD2 : read data (write-through on address match)
//   WE/WA/WD : write enable, address, data
// x0 always reads zero and is never written. Contents are not reset.
module decoder_reg_file
    import decoder_pkg::*;
#(
    parameter int unsigned W = XLEN,
    parameter int unsigned N = NREG
) (
    input  logic              CLK,
    input  logic [REG_AW-1:0] RA1,
    input  logic [REG_AW-1:0] RA2,
    output logic [W-1:0]      RD1,
    output logic [W-1:0]      RD2,
    input  logic              WE,
    input  logic [REG_AW-1:0] WA,
    input  logic [W-1:0]      WD
);

    logic [W-1:0] mem [N];

    // Write port; x0 is left untouched.
    always_ff @(posedge CLK) begin
        if (WE && WA != '0) begin
            mem[WA] <= WD;
        end
    end

    // Read ports with same-cycle write-through.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (RA1 != '0) begin
            RD1 = (WE && WA == RA1) ? WD : mem[RA1];
        end
        if (RA2 != '0) begin
            RD2 = (WE && WA == RA2) ? WD : mem[RA2];
        end
    end

endmodule

// File: rtl/decoder.sv
// Decode / operand-read stage between fetch and the executer.
//   CLK, RST            : clock, synchronous active-high reset
//   IN_VALID/IN_READY   : fetch handshake for INSTR
//   INSTR               : RV32I instruction word
//   OUT_VALID/OUT_READY : executer handshake for the registered bundle
//   CTR_INFO, RS1_VAL, RS2_VAL, IMM, RD_ADDR : registered operand bundle
//   WB_EN/WB_ADDR/WB_DATA : writeback port (register file write + scoreboard clear)
module decoder
    import decoder_pkg::*;
#(
    parameter int unsigned XLEN = decoder_pkg::XLEN,
    parameter int unsigned NREG = decoder_pkg::NREG
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [31:0]       INSTR,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output control_info_t     CTR_INFO,
    output logic [XLEN-1:0]   RS1_VAL,
    output logic [XLEN-1:0]   RS2_VAL,
    output logic [XLEN-1:0]   IMM,
    output logic [REG_AW-1:0] RD_ADDR,
    input  logic              WB_EN,
    input  logic [REG_AW-1:0] WB_ADDR,
    input  logic [XLEN-1:0]   WB_DATA
);

    decode_t           dec_c;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [REG_AW-1:0] rd_idx;
    logic [XLEN-1:0]   rs1_rd_c;
    logic [XLEN-1:0]   rs2_rd_c;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic              hazard_c;
    logic              accept_c;

    assign rs1_idx = INSTR[19:15];
    assign rs2_idx = INSTR[24:20];
    assign rd_idx  = INSTR[11:7];

    // Instruction decode.
    always_comb begin
        dec_c = decode_instr(INSTR);
    end

    decoder_reg_file #(
        .W (XLEN),
        .N (NREG)
    ) u_reg_file (
        .CLK (CLK),
        .RA1 (rs1_idx),
        .RA2 (rs2_idx),
        .RD1 (rs1_rd_c),
        .RD2 (rs2_rd_c),
        .WE  (WB_EN),
        .WA  (WB_ADDR),
        .WD  (WB_DATA)
    );

    // RAW hazard: a pending source is released by a writeback to it this cycle.
    always_comb begin
        hazard_c = 1'b0;
        if (dec_c.use_rs1 && pending_q[rs1_idx] && !(WB_EN && WB_ADDR == rs1_idx)) begin
            hazard_c = 1'b1;
        end
        if (dec_c.use_rs2 && pending_q[rs2_idx] && !(WB_EN && WB_ADDR == rs2_idx)) begin
            hazard_c = 1'b1;
        end
    end

    assign IN_READY = !hazard_c && (!OUT_VALID || OUT_READY);
    assign accept_c = IN_VALID && IN_READY;

    // Scoreboard next state: clear on writeback, then set on accept so set wins.
    always_comb begin
        pending_d = pending_q;
        if (WB_EN) begin
            pending_d[WB_ADDR] = 1'b0;
        end
        if (accept_c && dec_c.ctrl.wb_en && rd_idx != '0) begin
            pending_d[rd_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Output bundle and scoreboard registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            CTR_INFO  <= '0;
            RS1_VAL   <= '0;
            RS2_VAL   <= '0;
            IMM       <= '0;
            RD_ADDR   <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (accept_c) begin
                OUT_VALID <= 1'b1;
                CTR_INFO  <= dec_c.ctrl;
                RS1_VAL   <= rs1_rd_c;
                RS2_VAL   <= rs2_rd_c;
                IMM       <= XLEN'(dec_c.imm);
                RD_ADDR   <= rd_idx;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the decode / operand-read stage.
module tb_decoder;
    import decoder_pkg::*;

    logic          CLK;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [31:0]   INSTR;
    logic          OUT_VALID;
    logic          OUT_READY;
    control_info_t CTR_INFO;
    logic [31:0]   RS1_VAL;
    logic [31:0]   RS2_VAL;
    logic [31:0]   IMM;
    logic [4:0]    RD_ADDR;
    logic          WB_EN;
    logic [4:0]    WB_ADDR;
    logic [31:0]   WB_DATA;

    int n_cmp;
    int n_bad;

    localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] I_ADD_X3      = 32'h0020_81B3;
    localparam logic [31:0] I_ADDI_X9_1   = 32'h0010_0493;
    localparam logic [31:0] I_SUB_X5      = 32'h4073_02B3;
    localparam logic [31:0] I_SRAI_X8     = 32'h4030_D413;
    localparam logic [31:0] I_BAD         = 32'hFFFF_FFFF;
    localparam logic [31:0] I_LUI_X4      = 32'h1234_5237;
    localparam logic [31:0] I_ADDI_X2_1   = 32'h0010_0113;
    localparam logic [31:0] I_RD_X31      = 32'h000F_8033;
    localparam logic [31:0] I_RD_X2       = 32'h0001_0033;
    localparam logic [31:0] I_RD_X3       = 32'h0001_8033;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_SLTU,
        K_SLL, K_SRL, K_SRA, K_LUI, K_NONE
    } kind_e;

    decoder dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .CTR_INFO  (CTR_INFO),
        .RS1_VAL   (RS1_VAL),
        .RS2_VAL   (RS2_VAL),
        .IMM       (IMM),
        .RD_ADDR   (RD_ADDR),
        .WB_EN     (WB_EN),
        .WB_ADDR   (WB_ADDR),
        .WB_DATA   (WB_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1);
    end

    function automatic control_info_t mk_ctrl(input kind_e k, input logic imm,
                                              input logic wb, input logic ill);
        control_info_t c;
        c = '0;
        case (k)
            K_ADD:   c.op_add  = 1'b1;
            K_SUB:   c.op_sub  = 1'b1;
            K_AND:   c.op_and  = 1'b1;
            K_OR:    c.op_or   = 1'b1;
            K_XOR:   c.op_xor  = 1'b1;
            K_SLT:   c.op_slt  = 1'b1;
            K_SLTU:  c.op_sltu = 1'b1;
            K_SLL:   c.op_sll  = 1'b1;
            K_SRL:   c.op_srl  = 1'b1;
            K_SRA:   c.op_sra  = 1'b1;
            K_LUI:   c.op_lui  = 1'b1;
            default: ;
        endcase
        c.use_imm = imm;
        c.wb_en   = wb;
        c.illegal = ill;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        WB_EN   = 1'b1;
        WB_ADDR = a;
        WB_DATA = d;
        tick();
        WB_EN   = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        INSTR     = '0;
        OUT_READY = 1'b0;
        WB_EN     = 1'b0;
        WB_ADDR   = '0;
        WB_DATA   = '0;
        tick();
        tick();
        #1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_ctrl",      32'(CTR_INFO),  32'd0);
        chk("rst_rs1",       RS1_VAL,        32'd0);
        chk("rst_rs2",       RS2_VAL,        32'd0);
        chk("rst_imm",       IMM,            32'd0);
        chk("rst_rd",        32'(RD_ADDR),   32'd0);
        RST = 1'b0;

        wb_write(5'd2, 32'd7);
        wb_write(5'd6, 32'd10);
        wb_write(5'd7, 32'd3);

        // addi x1,x0,5
        IN_VALID = 1'b1; INSTR = I_ADDI_X1_5; OUT_READY = 1'b0;
        #1 chk("t1_in_ready", 32'(IN_READY), 32'd1);
        tick(); IN_VALID = 1'b0;
        #1;
        chk("t1_out_valid", 32'(OUT_VALID), 32'd1);
        chk("t1_ctrl",      32'(CTR_INFO),  32'(mk_ctrl(K_ADD, 1'b1, 1'b1, 1'b0)));
        chk("t1_imm",       IMM,            32'd5);
        chk("t1_rd",        32'(RD_ADDR),   32'd1);
        chk("t1_rs1",       RS1_VAL,        32'd0);

        // add x3,x1,x2 stalls on pending x1, then goes with the writeback bypass
        INSTR = I_ADD_X3; OUT_READY = 1'b1;
        #1 chk("t2_raw_stall", 32'(IN_READY), 32'd0);
        IN_VALID = 1'b1;
        tick();
        #1;
        chk("t2_drained",       32'(OUT_VALID), 32'd0);
        chk("t2_still_stalled", 32'(IN_READY),  32'd0);
        WB_EN = 1'b1; WB_ADDR = 5'd1; WB_DATA = 32'd5;
        #1 chk("t2_wb_release", 32'(IN_READY), 32'd1);
        tick(); WB_EN = 1'b0; IN_VALID = 1'b0;
        #1;
        chk("t2_out_valid", 32'(OUT_VALID), 32'd1);
        chk("t2_ctrl",      32'(CTR_INFO),  32'(mk_ctrl(K_ADD, 1'b0, 1'b1, 1'b0)));
        chk("t2_rs1_bypass", RS1_VAL,       32'd5);
        chk("t2_rs2",       RS2_VAL,        32'd7);
        chk("t2_imm",       IMM,            32'd0);
        chk("t2_rd",        32'(RD_ADDR),   32'd3);

        // Backpressure: bundle holds for three cycles
        OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = I_ADDI_X9_1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("t3_hold_ready", 32'(IN_READY),  32'd0);
            chk("t3_hold_valid", 32'(OUT_VALID), 32'd1);
            chk("t3_hold_rd",    32'(RD_ADDR),   32'd3);
            chk("t3_hold_rs1",   RS1_VAL,        32'd5);
        end
        OUT_READY = 1'b1;
        #1 chk("t3_release_ready", 32'(IN_READY), 32'd1);
        tick(); IN_VALID = 1'b0;
        #1;
        chk("t3_next_valid", 32'(OUT_VALID), 32'd1);
        chk("t3_next_rd",    32'(RD_ADDR),   32'd9);
        chk("t3_next_imm",   IMM,            32'd1);

        // sub x5,x6,x7
        INSTR = I_SUB_X5; IN_VALID = 1'b1;
        #1 chk("t4_in_ready", 32'(IN_READY), 32'd1);
        tick(); IN_VALID = 1'b0;
        #1;
        chk("t4_ctrl", 32'(CTR_INFO), 32'(mk_ctrl(K_SUB, 1'b0, 1'b1, 1'b0)));
        chk("t4_rs1",  RS1_VAL,       32'd10);
        chk("t4_rs2",  RS2_VAL,       32'd3);
        chk("t4_rd",   32'(RD_ADDR),  32'd5);

        // srai x8,x1,3
        INSTR = I_SRAI_X8; IN_VALID = 1'b1;
        tick(); IN_VALID = 1'b0;
        #1;
        chk("srai_ctrl", 32'(CTR_INFO), 32'(mk_ctrl(K_SRA, 1'b1, 1'b1, 1'b0)));
        chk("srai_imm",  IMM,           32'd3);
        chk("srai_rs1",  RS1_VAL,       32'd5);

        // Illegal word flows through and leaves the scoreboard alone
        INSTR = I_BAD; IN_VALID = 1'b1;
        tick(); IN_VALID = 1'b0;
        #1;
        chk("t5_bad_valid", 32'(OUT_VALID), 32'd1);
        chk("t5_bad_ctrl",  32'(CTR_INFO),  32'(mk_ctrl(K_NONE, 1'b0, 1'b0, 1'b1)));
        INSTR = I_RD_X31;
        #1 chk("t5_no_pending_x31", 32'(IN_READY), 32'd1);

        // lui x4,0x12345
        INSTR = I_LUI_X4; IN_VALID = 1'b1;
        tick(); IN_VALID = 1'b0;
        #1;
        chk("t5_lui_ctrl", 32'(CTR_INFO), 32'(mk_ctrl(K_LUI, 1'b1, 1'b1, 1'b0)));
        chk("t5_lui_imm",  IMM,           32'h1234_5000);
        chk("t5_lui_rd",   32'(RD_ADDR),  32'd4);

        // Set and clear of x2 in the same cycle: set wins
        INSTR = I_ADDI_X2_1; IN_VALID = 1'b1;
        WB_EN = 1'b1; WB_ADDR = 5'd2; WB_DATA = 32'd9;
        #1 chk("t6_in_ready", 32'(IN_READY), 32'd1);
        tick(); IN_VALID = 1'b0; WB_EN = 1'b0; INSTR = I_RD_X2;
        #1 chk("t6_set_wins", 32'(IN_READY), 32'd0);
        chk("t6_pre_rst_valid", 32'(OUT_VALID), 32'd1);

        // Reset with a held bundle
        OUT_READY = 1'b0; RST = 1'b1;
        tick();
        #1;
        chk("t6_rst_valid", 32'(OUT_VALID), 32'd0);
        chk("t6_rst_ctrl",  32'(CTR_INFO),  32'd0);
        chk("t6_rst_imm",   IMM,            32'd0);
        chk("t6_rst_rd",    32'(RD_ADDR),   32'd0);
        RST = 1'b0; OUT_READY = 1'b1; INSTR = I_RD_X2;
        #1 chk("t6_sb_clear_x2", 32'(IN_READY), 32'd1);
        INSTR = I_RD_X3;
        #1 chk("t6_sb_clear_x3", 32'(IN_READY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
